sma_engine: RTL

Computes six simple moving averages (windows 5, 10, 20, 50, 100, 200) over an incoming price stream. Sits directly upstream of the SMA trend/confluence stage and drives its `data_5`…`data_200` and `data_valid_pre` inputs. It keeps a 200-entry sample ring buffer and six running sums, updated with a short sequential read/update FSM per accepted sample. Averages come from reciprocal multiplication, so no divider is used.

---
 rtl/sma_if.sv | 28 ++
 rtl/sma_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sma_if.sv
// Price-stream handshake and moving-average result bundle.
// The upstream side drives the price; the averaging engine drives the results.
interface sma_if #(
    parameter int data_width = 16
);
    logic [data_width-1:0] price_in;
    logic                  price_valid;
    logic                  price_ready;
    logic [data_width-1:0] data_5;
    logic [data_width-1:0] data_10;
    logic [data_width-1:0] data_20;
    logic [data_width-1:0] data_50;
    logic [data_width-1:0] data_100;
    logic [data_width-1:0] data_200;
    logic                  data_valid_pre;

    modport master (
        output price_in, price_valid,
        input  price_ready, data_5, data_10, data_20, data_50, data_100, data_200,
        input  data_valid_pre
    );

    modport slave (
        input  price_in, price_valid,
        output price_ready, data_5, data_10, data_20, data_50, data_100, data_200,
        output data_valid_pre
    );
endinterface

// File: rtl/sma_engine.sv
// Six simple moving averages (windows 5..200) over a price stream, using a
// 200-entry ring buffer, running sums and reciprocal-multiply scaling.
//
// state | meaning
// IDLE  | ready for a sample; accept latches it
// READ  | six reads, one per window, of the sample leaving that window
// LAST  | fold in the final read, store new sample, advance pointer/count
// SCALE | register the six averages and the full-history pulse
module sma_engine #(
    parameter int data_width = 16
) (
    input  logic clk,
    input  logic rst,
    sma_if.slave bus_io
);
    localparam int DEPTH       = 200;
    localparam int RECIP_SHIFT = 24;

    typedef enum logic [1:0] {IDLE, READ, LAST, SCALE} state_t;

    function automatic logic [7:0] win_len(input logic [2:0] sel);
        case (sel)
            3'd0:    return 8'd5;
            3'd1:    return 8'd10;
            3'd2:    return 8'd20;
            3'd3:    return 8'd50;
            3'd4:    return 8'd100;
            default: return 8'd200;
        endcase
    endfunction

    function automatic logic [21:0] recip(input logic [2:0] sel);
        case (sel)
            3'd0:    return 22'd3355444;
            3'd1:    return 22'd1677722;
            3'd2:    return 22'd838861;
            3'd3:    return 22'd335545;
            3'd4:    return 22'd167773;
            default: return 22'd83887;
        endcase
    endfunction

    // Slot holding the sample that is leaving window sel once the new one lands.
    function automatic logic [7:0] rd_addr(input logic [7:0] ptr, input logic [2:0] sel);
        logic [7:0] n;
        n = win_len(sel);
        return (ptr >= n) ? (ptr - n) : (ptr + (8'd200 - n));
    endfunction

    function automatic logic [data_width-1:0] scale(input logic [23:0] s, input logic [21:0] k);
        logic [47:0] p;
        p = {24'd0, s} * {26'd0, k};
        return data_width'(p >> RECIP_SHIFT);
    endfunction

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [data_width-1:0] new_q, new_d;
    logic [7:0]            wr_ptr_q, wr_ptr_d;
    logic [7:0]            count_q, count_d;
    logic [23:0]           sum_q [6];
    logic [23:0]           sum_d [6];
    logic [data_width-1:0] data_q [6];
    logic [data_width-1:0] data_d [6];
    logic                  dv_q, dv_d;

    logic [data_width-1:0] mem [DEPTH];
    logic [data_width-1:0] rd_data_q;
    logic                  mem_we;
    logic [7:0]            mem_addr;
    logic                  upd_en;
    logic [2:0]            upd_sel;
    logic [data_width-1:0] old_val;

    // Contents are never read before being written for the window in question.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= new_q;
        end
        rd_data_q <= mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            new_q    <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dv_q     <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                sum_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            new_q    <= new_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dv_q     <= dv_d;
            for (int i = 0; i < 6; i++) begin
                sum_q[i]  <= sum_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        new_d    = new_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        sum_d    = sum_q;
        data_d   = data_q;
        dv_d     = 1'b0;
        mem_we   = 1'b0;
        mem_addr = rd_addr(wr_ptr_q, idx_q);
        upd_en   = 1'b0;
        upd_sel  = idx_q - 3'd1;

        case (state_q)
            IDLE: begin
                if (bus_io.price_valid) begin
                    new_d   = bus_io.price_in;
                    idx_d   = 3'd0;
                    state_d = READ;
                end
            end
            READ: begin
                upd_en = (idx_q != 3'd0);
                if (idx_q == 3'd5) begin
                    state_d = LAST;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            LAST: begin
                upd_en   = 1'b1;
                upd_sel  = 3'd5;
                mem_we   = 1'b1;
                mem_addr = wr_ptr_q;
                wr_ptr_d = (wr_ptr_q == 8'd199) ? 8'd0 : wr_ptr_q + 8'd1;
                if (count_q != 8'd200) begin
                    count_d = count_q + 8'd1;
                end
                state_d = SCALE;
            end
            SCALE: begin
                for (int i = 0; i < 6; i++) begin
                    data_d[i] = scale(sum_q[i], recip(3'(i)));
                end
                dv_d    = (count_q == 8'd200);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Windows not yet full have nothing to evict.
        old_val = (count_q < win_len(upd_sel)) ? '0 : rd_data_q;
        if (upd_en) begin
            sum_d[upd_sel] = sum_q[upd_sel] + 24'(new_q) - 24'(old_val);
        end
    end

    assign bus_io.price_ready    = (state_q == IDLE);
    assign bus_io.data_5         = data_q[0];
    assign bus_io.data_10        = data_q[1];
    assign bus_io.data_20        = data_q[2];
    assign bus_io.data_50        = data_q[3];
    assign bus_io.data_100       = data_q[4];
    assign bus_io.data_200       = data_q[5];
    assign bus_io.data_valid_pre = dv_q;
endmodule
